// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// req/addr are held until gnt; a single rvalid/rdata beat answers each granted request.
interface if_fetch_unit_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Single-outstanding instruction fetch: takes a next PC or boot request, fetches one word, hands it to Issue.
// Optional misaligned-PC trap to a NOP with fetch_err_o is enabled by defining FETCH_ALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  boot_i,
    input  logic                  pc_valid_i,
    input  logic [31:0]           pc_i,
    output logic                  pc_ready_o,
    if_fetch_unit_if.master       mem,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [31:0]           instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  fetch_err_o
);

    localparam int unsigned XLEN = 32;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              boot_pend_q, boot_pend_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   ipc_q, ipc_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              pc_ready_q, pc_ready_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    // State register and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= BOOT_ADDR;
            boot_pend_q <= 1'b0;
            instr_q     <= '0;
            ipc_q       <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            pc_ready_q  <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            boot_pend_q <= boot_pend_d;
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            pc_ready_q  <= pc_ready_d;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic; a boot seen mid-transaction discards the in-flight word and refetches BOOT_ADDR
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        boot_pend_d = boot_pend_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        err_d       = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (boot_i) begin
                    addr_d  = BOOT_ADDR;
                    state_d = S_REQ;
                end else if (pc_valid_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        instr_d = NOP_INSTR;
                        ipc_d   = pc_i;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        addr_d  = pc_i;
                        state_d = S_REQ;
                    end
`else
                    addr_d  = pc_i;
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (boot_i) begin
                    boot_pend_d = 1'b1;
                end
                if (mem.instr_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.instr_rvalid_i) begin
                    if (boot_pend_q || boot_i) begin
                        addr_d      = BOOT_ADDR;
                        boot_pend_d = 1'b0;
                        state_d     = S_REQ;
                    end else begin
                        instr_d = mem.instr_rdata_i;
                        ipc_d   = addr_q;
                        state_d = S_HOLD;
                    end
                end else if (boot_i) begin
                    boot_pend_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (boot_i) begin
                    addr_d      = BOOT_ADDR;
                    boot_pend_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    err_d       = 1'b0;
`endif
                    state_d     = S_REQ;
                end else if (instr_ready_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    err_d       = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d      = (state_d == S_REQ);
        valid_d    = (state_d == S_HOLD);
        pc_ready_d = (state_d == S_IDLE);
    end

    assign pc_ready_o       = pc_ready_q;
    assign mem.instr_req_o  = req_q;
    assign mem.instr_addr_o = {addr_q[XLEN-1:2], 2'b00};
    assign instr_valid_o    = valid_q;
    assign instr_o          = instr_q;
    assign instr_pc_o       = ipc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_err_o      = err_q;
`else
    assign fetch_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model with programmable gnt/rvalid latency and
// a scoreboard of expected (pc, instr, err) popped on each Issue handshake.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        boot_i = 1'b0;
    logic        pc_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        fetch_err_o;

    if_fetch_unit_if mem_bus ();

    if_fetch_unit #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .boot_i        (boot_i),
        .pc_valid_i    (pc_valid_i),
        .pc_i          (pc_i),
        .pc_ready_o    (pc_ready_o),
        .mem           (mem_bus.master),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .fetch_err_o   (fetch_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    int   gnt_delay = 0;
    int   rv_delay = 0;
    int   gnt_count = 0;
    bit   seen_dead = 0;
    bit   seen_3000 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0080) return 32'h0050_0093;
        if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Memory model: gnt after gnt_delay cycles of req, rvalid rv_delay cycles after the cycle following gnt
    initial begin
        int          cnt = 0;
        bit          pend = 0;
        int          pcnt = 0;
        logic [31:0] paddr = '0;
        mem_bus.instr_gnt_i    = 1'b0;
        mem_bus.instr_rvalid_i = 1'b0;
        mem_bus.instr_rdata_i  = '0;
        forever begin
            tick();
            mem_bus.instr_gnt_i    = 1'b0;
            mem_bus.instr_rvalid_i = 1'b0;
            mem_bus.instr_rdata_i  = '0;
            if (pend) begin
                if (pcnt == 0) begin
                    mem_bus.instr_rvalid_i = 1'b1;
                    mem_bus.instr_rdata_i  = mem_word(paddr);
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            if (mem_bus.instr_req_o) begin
                if (cnt < gnt_delay) begin
                    cnt++;
                end else begin
                    cnt = 0;
                    mem_bus.instr_gnt_i = 1'b1;
                    gnt_count++;
                    if (mem_bus.instr_addr_o == 32'h0000_3000) seen_3000 = 1;
                    pend  = 1;
                    pcnt  = rv_delay;
                    paddr = mem_bus.instr_addr_o;
                end
            end
        end
    end

    // Issue-side monitor: pop and compare on every accepted handshake (boot wins over ready)
    initial forever begin
        @(negedge clk_i);
        if (rst_ni && instr_valid_o && instr_o == 32'hDEAD_BEEF) seen_dead = 1;
        if (rst_ni && instr_valid_o && instr_ready_i && !boot_i) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", instr_o, e.instr);
                chk("sb_pc", instr_pc_o, e.pc);
                chk("sb_err", 32'(fetch_err_o), 32'(e.err));
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        exp_t e;
        e.pc = pc; e.instr = instr; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_pc_ready();
        for (int i = 0; i < 50 && !pc_ready_o; i++) tick();
        chk("pc_ready_timeout", 32'(pc_ready_o), 32'd1);
    endtask

    task automatic send_pc(input logic [31:0] pc);
        wait_pc_ready();
        pc_valid_i = 1'b1;
        pc_i       = pc;
        tick();
        pc_valid_i = 1'b0;
    endtask

    task automatic do_boot();
        boot_i = 1'b1;
        tick();
        boot_i = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !instr_valid_o; i++) tick();
        chk("valid_timeout", 32'(instr_valid_o), 32'd1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !mem_bus.instr_req_o; i++) tick();
        chk("req_timeout", 32'(mem_bus.instr_req_o), 32'd1);
    endtask

    task automatic consume();
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_req", 32'(mem_bus.instr_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", instr_pc_o, 32'd0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        chk("rst_pc_ready", 32'(pc_ready_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_pc_ready", 32'(pc_ready_o), 32'd1);

        // Boot fetch with zero-wait memory
        push_exp(32'h80, 32'h0050_0093, 1'b0);
        do_boot();
        chk("boot_req", 32'(mem_bus.instr_req_o), 32'd1);
        chk("boot_addr", mem_bus.instr_addr_o, 32'h80);
        chk("boot_pc_ready", 32'(pc_ready_o), 32'd0);
        wait_valid();
        chk("boot_instr", instr_o, 32'h0050_0093);
        chk("boot_ipc", instr_pc_o, 32'h80);
        consume();
        chk("boot_done_pc_ready", 32'(pc_ready_o), 32'd1);
        chk("boot_done_valid", 32'(instr_valid_o), 32'd0);

        // Delayed grant: request held stable for 4 cycles, exactly one gnt
        begin
            int g0;
            gnt_delay = 3;
            g0 = gnt_count;
            push_exp(32'h1000, mem_word(32'h1000), 1'b0);
            send_pc(32'h1000);
            for (int i = 0; i < 4; i++) begin
                chk("gnt_wait_req", 32'(mem_bus.instr_req_o), 32'd1);
                chk("gnt_wait_addr", mem_bus.instr_addr_o, 32'h1000);
                tick();
            end
            chk("after_gnt_req", 32'(mem_bus.instr_req_o), 32'd0);
            wait_valid();
            consume();
            chk("gnt_count", 32'(gnt_count - g0), 32'd1);
            gnt_delay = 0;
        end

        // Issue stalls 5 cycles in HOLD
        push_exp(32'h1100, mem_word(32'h1100), 1'b0);
        send_pc(32'h1100);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_instr", instr_o, mem_word(32'h1100));
            chk("hold_pc", instr_pc_o, 32'h1100);
            chk("hold_pc_ready", 32'(pc_ready_o), 32'd0);
            chk("hold_valid", 32'(instr_valid_o), 32'd1);
            tick();
        end
        consume();

        // Boot while waiting for 0x2000 response: DEADBEEF discarded, refetch 0x80
        rv_delay = 3;
        send_pc(32'h2000);
        tick();
        do_boot();
        rv_delay = 0;
        push_exp(32'h80, 32'h0050_0093, 1'b0);
        wait_req();
        chk("wait_boot_addr", mem_bus.instr_addr_o, 32'h80);
        wait_valid();
        chk("wait_boot_instr", instr_o, 32'h0050_0093);
        consume();

        // Boot and PC in the same IDLE cycle: boot wins
        wait_pc_ready();
        boot_i     = 1'b1;
        pc_valid_i = 1'b1;
        pc_i       = 32'h3000;
        tick();
        boot_i     = 1'b0;
        pc_valid_i = 1'b0;
        push_exp(32'h80, 32'h0050_0093, 1'b0);
        chk("tie_addr", mem_bus.instr_addr_o, 32'h80);
        wait_valid();
        consume();

        // Misaligned PC
        send_pc(32'h1002);
`ifdef FETCH_ALIGN_CHECK_EN
        push_exp(32'h1002, 32'h0000_0013, 1'b1);
        chk("mis_req", 32'(mem_bus.instr_req_o), 32'd0);
        chk("mis_valid", 32'(instr_valid_o), 32'd1);
        chk("mis_instr", instr_o, 32'h13);
        chk("mis_err", 32'(fetch_err_o), 32'd1);
        chk("mis_pc", instr_pc_o, 32'h1002);
        consume();
        chk("mis_err_clr", 32'(fetch_err_o), 32'd0);
`else
        push_exp(32'h1002, mem_word(32'h1000), 1'b0);
        chk("mis_req", 32'(mem_bus.instr_req_o), 32'd1);
        chk("mis_addr", mem_bus.instr_addr_o, 32'h1000);
        wait_valid();
        chk("mis_err", 32'(fetch_err_o), 32'd0);
        chk("mis_pc", instr_pc_o, 32'h1002);
        consume();
`endif

        // Boot in HOLD together with ready: held word discarded, refetch 0x80
        send_pc(32'h1200);
        wait_valid();
        boot_i        = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        boot_i        = 1'b0;
        instr_ready_i = 1'b0;
        chk("hold_boot_valid", 32'(instr_valid_o), 32'd0);
        chk("hold_boot_req", 32'(mem_bus.instr_req_o), 32'd1);
        chk("hold_boot_addr", mem_bus.instr_addr_o, 32'h80);
        push_exp(32'h80, 32'h0050_0093, 1'b0);
        wait_valid();
        consume();

        // Reset in WAIT; late response after release is ignored
        rv_delay = 2;
        send_pc(32'h1300);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid_o), 32'd0);
        chk("midrst_req", 32'(mem_bus.instr_req_o), 32'd0);
        chk("midrst_pc_ready", 32'(pc_ready_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        rv_delay = 0;
        tick();
        tick();
        tick();
        chk("postrst_valid", 32'(instr_valid_o), 32'd0);
        chk("postrst_req", 32'(mem_bus.instr_req_o), 32'd0);
        chk("postrst_pc_ready", 32'(pc_ready_o), 32'd1);

        // End-of-run bookkeeping
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("dead_never_seen", 32'(seen_dead), 32'd0);
        chk("no_3000_fetch", 32'(seen_3000), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Consumer end of the next-PC path: accepts the computed next PC, or a boot request, and fetches one instruction per PC from instruction memory.
- Uses a req/gnt/rvalid memory handshake.
- Presents the fetched word with its PC to Issue under a valid/ready handshake.
- Single outstanding transaction; sits between the PC computation stage and Issue.

Parameters:
- BOOT_ADDR, 32'h0000_0080: fetch address used on boot.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- boot_i  in  1  one-cycle pulse: restart fetching at BOOT_ADDR.
- pc_valid_i  in  1  next PC available.
- pc_i  in  32  next PC value.
- pc_ready_o  out  1  unit accepts a PC this cycle.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  memory word address.
- instr_gnt_i  in  1  memory accepted the request.
- instr_rvalid_i  in  1  read data valid.
- instr_rdata_i  in  32  read data.
- instr_valid_o  out  1  fetched instruction available to Issue.
- instr_o  out  32  fetched instruction.
- instr_pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  Issue consumes the instruction.
- fetch_err_o  out  1  misaligned fetch (see Optional Feature).

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State IDLE, addr register = BOOT_ADDR, boot_pend = 0.
  - instr_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, fetch_err_o = 0.
  - pc_ready_o = 1 in the first cycle after reset release.
- IDLE:
  - pc_ready_o = 1.
  - boot_i: addr <= BOOT_ADDR, go to REQ.
  - Else pc_valid_i: addr <= pc_i, go to REQ.
  - boot_i and pc_valid_i together: boot wins; the PC is not accepted (pc_ready_o still 1, so the source must treat it as dropped).
- REQ:
  - instr_req_o = 1, instr_addr_o = addr, both held stable until instr_gnt_i.
  - On gnt, go to WAIT. Earliest request is the cycle after the PC is accepted.
- WAIT:
  - instr_req_o = 0.
  - On instr_rvalid_i: instr_o <= instr_rdata_i, instr_pc_o <= addr, go to HOLD.
  - rvalid never arrives in the gnt cycle; the earliest is the cycle after.
- HOLD:
  - instr_valid_o = 1; instr_o and instr_pc_o stable until instr_ready_i.
  - On ready, go to IDLE.
- pc_ready_o = 0 in REQ, WAIT and HOLD.
- Minimum PC-to-next-PC acceptance: 4 cycles with zero-wait memory (accept, req/gnt, rvalid, handshake).
- boot_i outside IDLE: sets boot_pend.
  - REQ: the request still completes to gnt (address not changed mid-request); the response in WAIT is discarded.
  - WAIT: the response is discarded.
  - HOLD: instr_valid_o drops next cycle; the held word is discarded.
  - After any discard: addr <= BOOT_ADDR, boot_pend <= 0, go directly to REQ.
- boot_i in the same cycle as rvalid or instr_ready_i: the boot handling above takes priority; the word is never presented or consumed twice.
- Reset mid-transaction: immediate return to IDLE; any outstanding memory response after reset release is ignored (rvalid ignored outside WAIT).
- Address arithmetic: 32-bit, no wrap checking.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an accepted PC with pc_i[1:0] != 0 issues no memory request.
  - The unit goes straight to HOLD with instr_o = 32'h0000_0013 (NOP), instr_pc_o = pc_i, fetch_err_o = 1.
  - fetch_err_o clears when the word is consumed.
- Undefined:
  - instr_addr_o = {addr[31:2], 2'b00}.
  - fetch_err_o tied to 0.

Test Plan:
- Reset release then boot_i pulse, BOOT_ADDR = 0x80, zero-wait memory returning 0x00500093 -> instr_req_o with addr 0x80; instr_valid_o with instr_o = 0x00500093, instr_pc_o = 0x80; pc_ready_o high after instr_ready_i.
- pc_i = 0x1000 accepted, gnt delayed 3 cycles -> instr_addr_o stable at 0x1000 and instr_req_o high for all 4 cycles; exactly one gnt.
- instr_ready_i held low 5 cycles in HOLD -> instr_o and instr_pc_o unchanged; pc_ready_o = 0 throughout.
- boot_i in WAIT for pc 0x2000; rvalid brings 0xDEADBEEF -> 0xDEADBEEF never presented; next request at 0x80.
- boot_i and pc_valid_i (pc 0x3000) in the same IDLE cycle -> fetch at 0x80 only.
- FETCH_ALIGN_CHECK_EN defined, pc_i = 0x1002 -> no instr_req_o; instr_valid_o with instr_o = 0x00000013, fetch_err_o = 1, instr_pc_o = 0x1002. Undefined -> instr_addr_o = 0x1000, fetch_err_o = 0.
